// File: rtl/ibr_pkg.sv
// Shared types for the multi-channel block-cipher mode wrapper: chaining modes,
// controller states and small mode helpers.
package ibr_pkg;

   typedef enum logic [2:0] {
      MODE_ECB = 3'd0,
      MODE_CBC = 3'd1,
      MODE_CFB = 3'd2,
      MODE_OFB = 3'd3,
      MODE_CTR = 3'd4
   } ibr_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_OUT   = 2'd3
   } ibr_state_e;

   // Unused encodings collapse to ECB so a stray write never leaves a channel undefined.
   function automatic ibr_mode_e decode_mode(input logic [2:0] raw);
      case (raw)
         3'd1:    return MODE_CBC;
         3'd2:    return MODE_CFB;
         3'd3:    return MODE_OFB;
         3'd4:    return MODE_CTR;
         default: return MODE_ECB;
      endcase
   endfunction

   // Stream modes run the engine forward regardless of the channel direction.
   function automatic logic forces_encrypt(input ibr_mode_e m);
      return (m == MODE_CFB) || (m == MODE_OFB) || (m == MODE_CTR);
   endfunction

endpackage

// File: rtl/ibr_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr,
// wrapping, and returns it both one-hot and as an index.
module ibr_rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   grant_idx,
   output logic              grant_valid
);

   logic [2*NUM_CH-1:0] req_dbl;
   logic [NUM_CH-1:0]   req_rot;

   assign req_dbl = {req, req};

   // req_rot[k] is the request of channel (ptr + k) mod NUM_CH.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
         assign req_rot[gi] = req_dbl[int'(ptr) + gi];
      end
   endgenerate

   always_comb begin
      int offs;
      int sum;
      offs = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (req_rot[k]) offs = k;
      end
      sum = int'(ptr) + offs;
      if (sum >= NUM_CH) sum = sum - NUM_CH;
      grant_valid = |req;
      grant_idx   = CH_W'(sum);
      grant       = '0;
      if (grant_valid) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/ibr_mc_opmode.sv
// Multi-channel cipher mode wrapper: NUM_CH streams with their own mode, direction
// and chaining register share one external block-cipher engine, one block at a time.
module ibr_mc_opmode
   import ibr_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int BLOCK_W = 128,
   parameter int CTR_W   = 32,
   parameter int CH_W    = $clog2(NUM_CH)
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic                      cfg_we,
   input  logic [CH_W-1:0]           cfg_ch,
   input  logic [2:0]                cfg_mode,
   input  logic                      cfg_encrypt,
   input  logic [BLOCK_W-1:0]        cfg_iv,
   output logic                      cfg_ready,
   input  logic [NUM_CH-1:0]         in_valid,
   input  logic [NUM_CH*BLOCK_W-1:0] in_data,
   output logic [NUM_CH-1:0]         in_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CH_W-1:0]           out_ch,
   output logic [BLOCK_W-1:0]        out_data,
   output logic                      eng_start,
   output logic                      eng_encrypt,
   output logic [BLOCK_W-1:0]        eng_data,
   input  logic                      eng_ready,
   input  logic [BLOCK_W-1:0]        eng_result
);

   ibr_state_e          state_q, state_d;
   logic [CH_W-1:0]     ptr_q, ptr_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [BLOCK_W-1:0]  x_q, x_d;
   logic [BLOCK_W-1:0]  res_q, res_d;
   logic [BLOCK_W-1:0]  nr_q, nr_d;
   ibr_mode_e           mode_q  [NUM_CH];
   ibr_mode_e           mode_d  [NUM_CH];
   logic [NUM_CH-1:0]   enc_q, enc_d;
   logic [BLOCK_W-1:0]  chain_q [NUM_CH];
   logic [BLOCK_W-1:0]  chain_d [NUM_CH];

   logic [NUM_CH-1:0]   grant;
   logic [CH_W-1:0]     grant_idx;
   logic                grant_valid;

   ibr_mode_e           cur_mode;
   logic                cur_enc;
   logic [BLOCK_W-1:0]  cur_r;
   logic [BLOCK_W-1:0]  r_inc;
   logic [BLOCK_W-1:0]  eng_in;
   logic                eng_dir;
   logic [BLOCK_W-1:0]  blk_out;
   logic [BLOCK_W-1:0]  blk_nr;
   logic                eng_busy;

   ibr_rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_arb (
      .req         (in_valid),
      .ptr         (ptr_q),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // The in-flight channel's config and chain reg cannot change between accept
   // and retire, so reading them live keeps the engine inputs stable.
   assign cur_mode = mode_q[ch_q];
   assign cur_enc  = enc_q[ch_q];
   assign cur_r    = chain_q[ch_q];

   always_comb begin
      r_inc            = cur_r;
      r_inc[CTR_W-1:0] = cur_r[CTR_W-1:0] + CTR_W'(1);
      eng_in  = x_q;
      eng_dir = forces_encrypt(cur_mode) | cur_enc;
      blk_out = eng_result;
      blk_nr  = cur_r;
      case (cur_mode)
         MODE_CBC: begin
            if (cur_enc) begin
               eng_in = x_q ^ cur_r;
               blk_nr = eng_result;
            end else begin
               blk_out = eng_result ^ cur_r;
               blk_nr  = x_q;
            end
         end
         MODE_CFB: begin
            eng_in  = cur_r;
            blk_out = eng_result ^ x_q;
            blk_nr  = cur_enc ? (eng_result ^ x_q) : x_q;
         end
         MODE_OFB: begin
            eng_in  = cur_r;
            blk_out = eng_result ^ x_q;
            blk_nr  = eng_result;
         end
         MODE_CTR: begin
            eng_in  = cur_r;
            blk_out = eng_result ^ x_q;
            blk_nr  = r_inc;
         end
         default: ;
      endcase
   end

   assign eng_busy    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign eng_start   = (state_q == ST_ISSUE);
   assign eng_data    = eng_busy ? eng_in : '0;
   assign eng_encrypt = eng_busy & eng_dir;
   assign out_valid   = (state_q == ST_OUT);
   assign out_ch      = out_valid ? ch_q : '0;
   assign out_data    = res_q;
   assign in_ready    = (state_q == ST_IDLE) ? grant : '0;
   assign cfg_ready   = !((state_q != ST_IDLE) && (cfg_ch == ch_q));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      ch_d    = ch_q;
      x_d     = x_q;
      res_d   = res_q;
      nr_d    = nr_q;
      mode_d  = mode_q;
      enc_d   = enc_q;
      chain_d = chain_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               ch_d    = grant_idx;
               x_d     = in_data[grant_idx*BLOCK_W +: BLOCK_W];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (eng_ready) begin
               res_d   = blk_out;
               nr_d    = blk_nr;
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               chain_d[ch_q] = nr_q;
               ptr_d   = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // cfg_ready keeps this away from the channel whose chain reg is retiring.
      if (cfg_we && cfg_ready && (int'(cfg_ch) < NUM_CH)) begin
         mode_d[cfg_ch]  = decode_mode(cfg_mode);
         enc_d[cfg_ch]   = cfg_encrypt;
         chain_d[cfg_ch] = cfg_iv;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         ch_q    <= '0;
         x_q     <= '0;
         res_q   <= '0;
         nr_q    <= '0;
         enc_q   <= '1;
         for (int i = 0; i < NUM_CH; i++) begin
            mode_q[i]  <= MODE_ECB;
            chain_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ch_q    <= ch_d;
         x_q     <= x_d;
         res_q   <= res_d;
         nr_q    <= nr_d;
         enc_q   <= enc_d;
         mode_q  <= mode_d;
         chain_q <= chain_d;
      end
   end

endmodule
